// File: rtl/alu_exec_ctrl_pkg.sv
// Shared op-code constants and sequencer state encoding for the MicroUAZ
// operand-latch / execution block.
package alu_exec_ctrl_pkg;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NOT   = 3'd3;
   localparam logic [2:0] OP_ADD   = 3'd4;
   localparam logic [2:0] OP_SUB   = 3'd5;
   localparam logic [2:0] OP_PASSA = 3'd6;
   localparam logic [2:0] OP_PASSB = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_exec_ctrl_core.sv
// Combinational op-unit bank: per-bit logic units, one shared adder/subtractor,
// and a result mux selected by op. Logic/pass ops forward carry_in untouched.
module alu_core
   import alu_exec_ctrl_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   input  logic [2:0]   op,
   input  logic         carry_in,
   output logic [N-1:0] result,
   output logic         carry_out
);

   logic [N-1:0] and_bits;
   logic [N-1:0] or_bits;
   logic [N-1:0] xor_bits;
   logic [N-1:0] not_bits;
   logic [N-1:0] b_mux;
   logic [N:0]   sum;
   logic         sub;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign and_bits[gi] = op_a[gi] & op_b[gi];
         assign or_bits[gi]  = op_a[gi] | op_b[gi];
         assign xor_bits[gi] = op_a[gi] ^ op_b[gi];
         assign not_bits[gi] = ~op_a[gi];
      end
   endgenerate

   // Subtract as A + ~B + 1; the adder's carry-out is then "no borrow".
   assign sub   = (op == OP_SUB);
   assign b_mux = sub ? ~op_b : op_b;
   assign sum   = {1'b0, op_a} + {1'b0, b_mux} + {{N{1'b0}}, sub};

   always_comb begin
      result    = '0;
      carry_out = carry_in;
      case (op)
         OP_AND:   result = and_bits;
         OP_OR:    result = or_bits;
         OP_XOR:   result = xor_bits;
         OP_NOT:   result = not_bits;
         OP_ADD: begin
            result    = sum[N-1:0];
            carry_out = sum[N];
         end
         OP_SUB: begin
            result    = sum[N-1:0];
            carry_out = ~sum[N];
         end
         OP_PASSA: result = op_a;
         OP_PASSB: result = op_b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Operand registers, IDLE/EXEC/WB sequencer, accumulator and Z/N/C flags with a
// start/busy/done handshake towards the control unit.
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] bus_in,
   input  logic         load_a,
   input  logic         load_b,
   input  logic [2:0]   op,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] op_a,
   output logic [N-1:0] op_b,
   output logic [N-1:0] acc,
   output logic         flag_z,
   output logic         flag_n,
   output logic         flag_c
);

   state_t       state_reg, state_next;
   logic [2:0]   op_reg;
   logic [N-1:0] a_reg, b_reg, acc_reg;
   logic         z_reg, n_reg, c_reg, done_reg;
   logic         idle, wb_en;
   logic [N-1:0] result;
   logic         carry_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = EXEC;
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      idle  = (state_reg == IDLE);
      wb_en = (state_reg == WB);
      busy  = (state_reg != IDLE);
   end

   alu_core #(.N(N)) u_core (
      .op_a      (a_reg),
      .op_b      (b_reg),
      .op        (op_reg),
      .carry_in  (c_reg),
      .result    (result),
      .carry_out (carry_out)
   );

   // Operands and op are only writable in IDLE, so they stay frozen through EXEC/WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= '0;
         acc_reg  <= '0;
         z_reg    <= 1'b1;
         n_reg    <= 1'b0;
         c_reg    <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= wb_en;
         if (idle) begin
            if (load_a) a_reg <= bus_in;
            if (load_b) b_reg <= bus_in;
            if (start)  op_reg <= op;
         end
         if (wb_en) begin
            acc_reg <= result;
            z_reg   <= (result == '0);
            n_reg   <= result[N-1];
            c_reg   <= carry_out;
         end
      end
   end

   assign done   = done_reg;
   assign op_a   = a_reg;
   assign op_b   = b_reg;
   assign acc    = acc_reg;
   assign flag_z = z_reg;
   assign flag_n = n_reg;
   assign flag_c = c_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_alu_exec_ctrl;
   import alu_exec_ctrl_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] bus_in = '0;
   logic         load_a = 1'b0, load_b = 1'b0, start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic         busy, done, flag_z, flag_n, flag_c;
   logic [N-1:0] op_a, op_b, acc;

   int checks = 0;
   int errors = 0;

   // Model state: operands, architectural outputs, and one pending result.
   logic [N-1:0] m_a, m_b, m_acc, p_acc;
   logic         m_z, m_n, m_c, m_done, p_c, p_arith;
   int           m_left;

   alu_exec_ctrl #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_in (bus_in),
      .load_a (load_a),
      .load_b (load_b),
      .op     (op),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .op_a   (op_a),
      .op_b   (op_b),
      .acc    (acc),
      .flag_z (flag_z),
      .flag_n (flag_n),
      .flag_c (flag_c)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_a = '0; m_b = '0; m_acc = '0;
      m_z = 1'b1; m_n = 1'b0; m_c = 1'b0;
      m_done = 1'b0; m_left = 0;
      p_acc = '0; p_c = 1'b0; p_arith = 1'b0;
   endfunction

   // Result is computed at acceptance time and becomes visible two edges later.
   function automatic void model_step();
      int unsigned ua, ub, r;
      m_done = 1'b0;
      if (m_left == 0) begin
         if (load_a) m_a = bus_in;
         if (load_b) m_b = bus_in;
         if (start) begin
            ua = m_a; ub = m_b;
            p_arith = 1'b0; p_c = 1'b0;
            case (op)
               3'd0: r = ua & ub;
               3'd1: r = ua | ub;
               3'd2: r = ua ^ ub;
               3'd3: r = ~ua;
               3'd4: begin r = ua + ub; p_arith = 1'b1; p_c = (r > 255); end
               3'd5: begin r = ua - ub; p_arith = 1'b1; p_c = (ua < ub); end
               3'd6: r = ua;
               default: r = ub;
            endcase
            p_acc  = r[N-1:0];
            m_left = 2;
         end
      end else if (m_left == 2) begin
         m_left = 1;
      end else begin
         m_acc = p_acc;
         m_z   = (p_acc == '0);
         m_n   = p_acc[N-1];
         if (p_arith) m_c = p_c;
         m_done = 1'b1;
         m_left = 0;
      end
   endfunction

   task automatic compare_all();
      chk("busy",   busy,   m_left != 0);
      chk("done",   done,   m_done);
      chk("acc",    acc,    m_acc);
      chk("flag_z", flag_z, m_z);
      chk("flag_n", flag_n, m_n);
      chk("flag_c", flag_c, m_c);
      chk("op_a",   op_a,   m_a);
      chk("op_b",   op_b,   m_b);
      if (done === 1'b1)
         $display("TXN t=%0t acc=%02h z=%0b n=%0b c=%0b", $time, acc, flag_z, flag_n, flag_c);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input logic [N-1:0] b, input logic la, input logic lb,
                        input logic st, input logic [2:0] o);
      bus_in = b; load_a = la; load_b = lb; start = st; op = o;
   endtask

   // Load A, load B, start; returns at the negedge after e2 (done expected high).
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] o);
      drive(a, 1'b1, 1'b0, 1'b0, 3'd0); cycle();
      drive(b, 1'b0, 1'b1, 1'b0, 3'd0); cycle();
      drive('0, 1'b0, 1'b0, 1'b1, o);   cycle();
      chk("busy_e0", busy, 1'b1);
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
      chk("busy_e1", busy, 1'b1);
      cycle();
      chk("done_e2", done, 1'b1);
      chk("busy_e2", busy, 1'b0);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_acc", acc, 8'h00);
      chk("rst_z", flag_z, 1'b1);
      chk("rst_n", flag_n, 1'b0);
      chk("rst_c", flag_c, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst_n = 1'b1;
      cycle();

      run_op(8'hF0, 8'h3C, OP_AND);
      chk("and_acc", acc, 8'h30); chk("and_z", flag_z, 1'b0);
      chk("and_n", flag_n, 1'b0); chk("and_c", flag_c, 1'b0);
      cycle();
      chk("done_clear", done, 1'b0);

      run_op(8'hFF, 8'h01, OP_ADD);
      chk("add_acc", acc, 8'h00); chk("add_z", flag_z, 1'b1); chk("add_c", flag_c, 1'b1);
      run_op(8'hFF, 8'h01, OP_OR);
      chk("or_acc", acc, 8'hFF); chk("or_n", flag_n, 1'b1); chk("or_c_kept", flag_c, 1'b1);

      run_op(8'h05, 8'h07, OP_SUB);
      chk("sub1_acc", acc, 8'hFE); chk("sub1_n", flag_n, 1'b1); chk("sub1_c", flag_c, 1'b1);
      run_op(8'h07, 8'h05, OP_SUB);
      chk("sub2_acc", acc, 8'h02); chk("sub2_c", flag_c, 1'b0);

      // Start and load_a while busy are dropped; start on the done cycle is taken.
      drive('0, 1'b0, 1'b0, 1'b1, OP_PASSA); cycle();
      drive(8'hAA, 1'b1, 1'b0, 1'b1, OP_SUB); cycle();
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
      chk("busy_load_ignored", op_a, 8'h07);
      chk("passa_acc", acc, 8'h07);
      drive('0, 1'b0, 1'b0, 1'b1, OP_PASSB); cycle();
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
      chk("b2b_no_early_done", done, 1'b0);
      cycle();
      chk("b2b_done", done, 1'b1);
      chk("passb_acc", acc, 8'h05);

      // Same-cycle load + start uses the freshly loaded operand.
      drive(8'h81, 1'b1, 1'b1, 1'b1, OP_ADD); cycle();
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0); cycle(); cycle();
      chk("ldstart_acc", acc, 8'h02); chk("ldstart_c", flag_c, 1'b1);

      // Reset in EXEC aborts at once with no done.
      drive(8'h33, 1'b1, 1'b0, 1'b1, OP_PASSA); cycle();
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0); chk("abort_done", done, 1'b0);
      chk("abort_acc", acc, 8'h00); chk("abort_z", flag_z, 1'b1);
      chk("abort_c", flag_c, 1'b0); chk("abort_a", op_a, 8'h00);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h12, 8'h34, OP_XOR);
      chk("post_rst_acc", acc, 8'h26);

      for (int i = 0; i < 400; i++) begin
         drive(N'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
         cycle();
      end
      drive('0, 1'b0, 1'b0, 1'b0, 3'd0);
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Operand-latch and execution sequencer for the MicroUAZ datapath.
- Sits directly upstream of the N-bit logic/arithmetic op units (AND, OR, XOR, NOT, ADD, SUB) and feeds them registered operands A and B.
- Selects and captures the chosen unit's result into an accumulator, updates Z/N/C flags, and signals completion to the control unit with a start/busy/done handshake.

Parameters:
- N, 8, datapath width of operands, accumulator and bus.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_in  in  N  data bus value for operand loads.
- load_a  in  1  load bus_in into operand register A.
- load_b  in  1  load bus_in into operand register B.
- op  in  3  operation code, sampled with start.
- start  in  1  request execution of op on the current A/B.
- busy  out  1  high while an operation is in flight (state != IDLE).
- done  out  1  one-cycle pulse when acc/flags have been updated.
- op_a  out  N  registered operand A, to the op units.
- op_b  out  N  registered operand B, to the op units.
- acc  out  N  accumulator (last result).
- flag_z  out  1  result == 0.
- flag_n  out  1  result MSB.
- flag_c  out  1  carry/borrow.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: A, B, acc = 0; flag_z = 1, flag_n = 0, flag_c = 0; done = 0; state = IDLE; latched op = 0.
- Op codes:
  - 0 AND; 1 OR; 2 XOR; 3 NOT A.
  - 4 ADD (A+B, C = carry out of bit N-1).
  - 5 SUB (A-B, C = 1 when A < B unsigned, i.e. borrow).
  - 6 PASS A; 7 PASS B.
  - Logic and pass ops leave flag_c unchanged.
- All results are truncated to N bits. Z and N are computed on the truncated result.
- FSM has three states: IDLE, EXEC, WB.
  - IDLE: start=1 at an edge latches op, goes to EXEC. start=0 stays in IDLE.
  - EXEC: op_a/op_b are held stable for the op units; next edge goes to WB unconditionally.
  - WB: on the next edge, result is written to acc, flags update, done is set to 1, state returns to IDLE.
- done clears on the following edge.
- Latency: start sampled at edge e0 → acc/flags valid and done=1 after edge e2. done falls at e3.
- Throughput: one op per 3 cycles. start asserted on the same cycle done is high is accepted, since the state is IDLE.
- busy is combinational from state: high after e0 through e2.
- Operand loads:
  - load_a/load_b are honoured only in IDLE and ignored while busy.
  - A load in the same IDLE cycle as start takes effect on that edge; the operation then uses the newly loaded value.
  - load_a and load_b asserted together both load bus_in.
- start while busy is ignored (not queued).
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced.

Decomposition:
- Shared package/header contains:
  - op-code constants OP_AND..OP_PASSB (3 bits);
  - state encodings IDLE=2'd0, EXEC=2'd1, WB=2'd2.
- One natural sub-module: alu_core, a combinational block taking op_a, op_b, op and carry_in, producing result[N-1:0] and carry_out.
  - It instantiates the existing per-operation units (N-bit AND etc.) and an adder/subtractor, then muxes by op.
- alu_exec_ctrl holds the registers, FSM and flag logic.

Test Plan:
- Reset then idle → acc=0x00, flag_z=1, flag_n=0, flag_c=0, busy=0, done=0.
- Load A=0xF0, B=0x3C, start op=AND → busy high 2 cycles, done pulse at e2, acc=0x30, Z=0, N=0, C unchanged.
- A=0xFF, B=0x01, op=ADD → acc=0x00, Z=1, C=1; then op=OR with the same operands → acc=0xFF, N=1, C still 1.
- A=0x05, B=0x07, op=SUB → acc=0xFE, N=1, C=1. Then A=0x07, B=0x05 → acc=0x02, C=0.
- While busy: pulse start, load_a with bus_in=0xAA → no new operation, A unchanged. Start on the done cycle → accepted, next done 3 cycles later.
- rst_n low during EXEC → all outputs return to reset values at once, no done. After release, a fresh op works normally.
